sr_latch_ctrl: RTL

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

---
 rtl/sr_latch_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sr_latch_ctrl.sv
// Arbitrated set/clear controller for a shared NAND SR latch: pulses the
// active-low latch inputs, checks the fed-back latch state and acknowledges the requester.
module sr_latch_ctrl #(
  parameter int PULSE_CYC = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic op_a,
  input  logic op_b,
  output logic ack_a,
  output logic ack_b,
  output logic s_n,
  output logic r_n,
  input  logic q,
  input  logic q_bar,
  output logic busy,
  output logic err,
  input  logic err_clr
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_VERIFY  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] RECOV_LD = 4'(RECOV_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic       gnt_b_q, gnt_b_d;
  logic       last_b_q, last_b_d;
  logic       red_q, red_d;
  logic       err_q, err_d;
  logic       s_n_q, s_n_d;
  logic       r_n_q, r_n_d;

  logic       grant_a, grant_b, sel_op, redundant, match, err_set;
  logic       verify_ok, done;

  // Round-robin: on a tie, A wins only when B was granted last.
  assign grant_a   = req_a && (!req_b || last_b_q);
  assign grant_b   = req_b && !grant_a;
  assign sel_op    = grant_a ? op_a : op_b;
  assign redundant = (q == sel_op) && (q_bar == ~sel_op);
  assign match     = (q == op_q) && (q_bar == ~op_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    gnt_b_d  = gnt_b_q;
    last_b_d = last_b_q;
    red_d    = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_a || grant_b) begin
          gnt_b_d  = grant_b;
          last_b_d = grant_b;
          op_d     = sel_op;
          if (redundant) begin
            state_d = ST_RECOVER;
            cnt_d   = RECOV_LD;
            red_d   = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = PULSE_LD;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) state_d = ST_VERIFY;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_VERIFY: begin
        state_d = ST_RECOVER;
        cnt_d   = RECOV_LD;
        err_set = !match;
      end
      ST_RECOVER: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    // Only one latch input can ever be low: the pair is decoded from a single op bit.
    s_n_d = !((state_d == ST_DRIVE) && op_d);
    r_n_d = !((state_d == ST_DRIVE) && !op_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_b_q <= 1'b1;
      red_q    <= 1'b0;
      err_q    <= 1'b0;
      s_n_q    <= 1'b1;
      r_n_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      red_q    <= red_d;
      err_q    <= err_d;
      s_n_q    <= s_n_d;
      r_n_q    <= r_n_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    op_q    <= op_d;
    gnt_b_q <= gnt_b_d;
  end

  // A redundant op acknowledges in the first RECOVER cycle, a driven op in VERIFY.
  assign verify_ok = (state_q == ST_VERIFY) && match;
  assign done      = verify_ok || ((state_q == ST_RECOVER) && red_q);

  assign ack_a = done && !gnt_b_q;
  assign ack_b = done && gnt_b_q;
  assign s_n   = s_n_q;
  assign r_n   = r_n_q;
  assign busy  = (state_q != ST_IDLE);
  assign err   = err_q;

endmodule
